// File: rtl/chinpo_pkg.sv
// rtl/chinpo_pkg.sv - shared CHINPO fetch/decode constants
package chinpo_pkg;

  // Fetch FSM state encodings
  localparam logic [0:0] F_IDLE = 1'b0;
  localparam logic [0:0] F_WAIT = 1'b1;

  // Opcode field position inside a 16-bit instruction word
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Instruction loaded on a timed-out fetch; decoded as a no-op by the control unit
  localparam logic [15:0] IR_NOP = 16'h0000;

endpackage

// File: rtl/chinpo_fetch_watchdog.sv
// rtl/chinpo_fetch_watchdog.sv - wait-cycle counter and terminal-count compare for a stalled fetch
module chinpo_fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic start,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire
);

  logic [7:0] count;

  // Count F_WAIT cycles that end without mem_ready; restart on every accepted fetch
  always_ff @(posedge CLK) begin
    if (Reset || start) begin
      count <= 8'd0;
    end else if (waiting && !mem_ready) begin
      count <= count + 8'd1;
    end
  end

  // Fires on the TIMEOUT-th unanswered wait cycle; a same-cycle mem_ready still wins
  assign expire = waiting && !mem_ready && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/chinpo_fetch_unit.sv
// rtl/chinpo_fetch_unit.sv - PC/IR owner and instruction-memory handshake; optional FETCH_TIMEOUT_EN watchdog
module chinpo_fetch_unit
  import chinpo_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IRWrite,
  input  logic              PCWrite,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [3:0]        Opcode,
  output logic              IR0,
  output logic              IR1,
  output logic              IR2,
  output logic              IR3,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic [1:0]        fetch_err
);

  logic [0:0] state;
  logic       start;
  logic       waiting;
  logic       timeout_hit;

  assign start   = (state == F_IDLE) && IRWrite;
  assign waiting = (state == F_WAIT);

`ifdef FETCH_TIMEOUT_EN
  chinpo_fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (start),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .expire    (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(8'(TIMEOUT));
  assign timeout_hit        = 1'b0;
`endif

  // Fetch FSM, PC/IR registers and sticky error flags
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= F_IDLE;
      PC        <= RESET_PC;
      IR        <= '0;
      mem_addr  <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 2'b00;
    end else begin
      ir_valid <= 1'b0;
      if (PCWrite) begin
        PC <= pc_next;
      end
      // A request arriving while a fetch is outstanding (including its last cycle) is dropped
      if (IRWrite && (state == F_WAIT)) begin
        fetch_err[0] <= 1'b1;
      end
      if (timeout_hit) begin
        fetch_err[1] <= 1'b1;
      end
      if (state == F_IDLE) begin
        if (IRWrite) begin
          mem_addr <= PC;
          state    <= F_WAIT;
        end
      end else begin
        if (mem_ready) begin
          IR       <= mem_rdata;
          ir_valid <= 1'b1;
          state    <= F_IDLE;
        end else if (timeout_hit) begin
          IR       <= DATA_W'(IR_NOP);
          ir_valid <= 1'b1;
          state    <= F_IDLE;
        end
      end
    end
  end

  // Request and busy are both exactly "a fetch is outstanding"
  assign mem_req    = waiting;
  assign fetch_busy = waiting;

  assign Opcode = IR[DATA_W-1 -: OPCODE_W];
  assign IR0    = IR[0];
  assign IR1    = IR[1];
  assign IR2    = IR[2];
  assign IR3    = IR[3];

endmodule
